// File: rtl/nibble_alu_sequencer.sv
// -----------------------------------------------------------------------------
// nibble_alu_sequencer
//
// Purpose:
//   Initiator side of a 4-bit ALU request interface. One WIDTH-bit operation
//   (add, sub, and, or) is accepted over a valid/ready handshake. It is split
//   into WIDTH/4 nibble requests, issued LSB nibble first, with carry/borrow
//   chained between nibbles. The reassembled result is returned on a
//   valid/ready response port. If the ALU does not answer within TIMEOUT+1
//   WAIT cycles, the operation is aborted and reported with rsp_err.
//
// Parameters:
//   WIDTH   - operand/result width, multiple of 4, minimum 4 (default 16)
//   TIMEOUT - WAIT cycles tolerated without alu_valid, 1..255 (default 15)
//
// Ports:
//   clk, rst              - clock (rising edge), asynchronous active-high reset
//   req_valid / req_ready - request handshake (req_ready is 0 while rst is high)
//   req_a, req_b, req_op  - operands and opcode (00 add, 01 sub, 10 and, 11 or)
//   rsp_valid / rsp_ready - response handshake
//   rsp_s, rsp_cout       - result and final carry/borrow (0 for and/or)
//   rsp_err               - operation aborted by timeout
//   alu_req               - one-cycle pulse launching a nibble operation
//   alu_a, alu_b, alu_op  - nibble operands and opcode, stable until answered
//   alu_cin               - carry-in (add) / borrow-in (sub), 0 for and/or
//   alu_s, alu_cout       - nibble result and carry/borrow-out from the ALU
//   alu_valid             - nibble result valid (only honoured in WAIT)
//
// Optional feature (macro NIBBLE_ALU_SEQUENCER_FLAGS_EN):
//   Adds rsp_zero (result is zero) and rsp_ovf (signed overflow for add/sub),
//   registered with rsp_s. Both are 0 after a timeout.
// -----------------------------------------------------------------------------
module nibble_alu_sequencer #(
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [1:0]       req_op,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_s,
  output logic             rsp_cout,
  output logic             rsp_err,
`ifdef NIBBLE_ALU_SEQUENCER_FLAGS_EN
  output logic             rsp_zero,
  output logic             rsp_ovf,
`endif
  output logic             alu_req,
  output logic [3:0]       alu_a,
  output logic [3:0]       alu_b,
  output logic [1:0]       alu_op,
  output logic             alu_cin,
  input  logic [3:0]       alu_s,
  input  logic             alu_cout,
  input  logic             alu_valid
);

  localparam int N  = WIDTH / 4;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int TW = 8;

  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
  localparam logic [TW-1:0] TMO      = TW'(TIMEOUT);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [1:0]       op_q, op_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_cout_q, rsp_cout_d;
  logic             rsp_err_q, rsp_err_d;
  logic             alu_req_q, alu_req_d;
  logic [3:0]       alu_a_q, alu_a_d;
  logic [3:0]       alu_b_q, alu_b_d;
  logic [1:0]       alu_op_q, alu_op_d;
  logic             alu_cin_q, alu_cin_d;
`ifdef NIBBLE_ALU_SEQUENCER_FLAGS_EN
  logic             rsp_zero_q, rsp_zero_d;
  logic             rsp_ovf_q, rsp_ovf_d;
`endif

  logic accept;
  logic is_arith;

  // Gated by rst so a client never sees a ready during the reset pulse.
  assign req_ready = (state_q == IDLE) && !rst;
  assign accept    = req_valid && req_ready;
  assign is_arith  = (op_q == OP_ADD) || (op_q == OP_SUB);

  // ---------------------------------------------------------------------------
  // Next-state and output logic. All outputs are registered: their next value
  // is derived from the next state so that alu_req lines up exactly with the
  // single ISSUE cycle and rsp_valid with DONE.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    idx_d       = idx_q;
    carry_d     = carry_q;
    timer_d     = timer_q;
    res_d       = res_q;
    rsp_cout_d  = rsp_cout_q;
    rsp_err_d   = rsp_err_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_op_d    = alu_op_q;
    alu_cin_d   = alu_cin_q;
`ifdef NIBBLE_ALU_SEQUENCER_FLAGS_EN
    rsp_zero_d  = rsp_zero_q;
    rsp_ovf_d   = rsp_ovf_q;
`endif

    case (state_q)
      IDLE: begin
        if (accept) begin
          a_d        = req_a;
          b_d        = req_b;
          op_d       = req_op;
          idx_d      = '0;
          carry_d    = 1'b0;
          res_d      = '0;
          rsp_cout_d = 1'b0;
          rsp_err_d  = 1'b0;
`ifdef NIBBLE_ALU_SEQUENCER_FLAGS_EN
          rsp_zero_d = 1'b0;
          rsp_ovf_d  = 1'b0;
`endif
          state_d    = ISSUE;
        end
      end

      ISSUE: begin
        timer_d = '0;
        state_d = WAIT;
      end

      WAIT: begin
        // A response in the same cycle as timer expiry still counts.
        if (alu_valid) begin
          for (int i = 0; i < N; i++) begin
            if (idx_q == IW'(i)) begin
              res_d[4*i +: 4] = alu_s;
            end
          end
          carry_d = alu_cout;
          if (idx_q == LAST_IDX) begin
            rsp_cout_d = is_arith ? alu_cout : 1'b0;
`ifdef NIBBLE_ALU_SEQUENCER_FLAGS_EN
            rsp_zero_d = (res_d == '0);
            if (op_q == OP_ADD) begin
              rsp_ovf_d = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                          (res_d[WIDTH-1] != a_q[WIDTH-1]);
            end else if (op_q == OP_SUB) begin
              rsp_ovf_d = (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                          (res_d[WIDTH-1] != a_q[WIDTH-1]);
            end else begin
              rsp_ovf_d = 1'b0;
            end
`endif
            state_d = DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = ISSUE;
          end
        end else if (timer_q == TMO) begin
          // Abort: nibbles never answered stay 0 in the result.
          rsp_err_d  = 1'b1;
          rsp_cout_d = 1'b0;
`ifdef NIBBLE_ALU_SEQUENCER_FLAGS_EN
          rsp_zero_d = 1'b0;
          rsp_ovf_d  = 1'b0;
`endif
          state_d    = DONE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      DONE: begin
        if (rsp_ready) begin
          rsp_err_d = 1'b0;
          state_d   = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Drive the nibble operands only when launching; they then hold through
    // WAIT because the registers simply keep their value.
    alu_req_d = (state_d == ISSUE);
    if (state_d == ISSUE) begin
      for (int i = 0; i < N; i++) begin
        if (idx_d == IW'(i)) begin
          alu_a_d = a_d[4*i +: 4];
          alu_b_d = b_d[4*i +: 4];
        end
      end
      alu_op_d  = op_d;
      alu_cin_d = op_d[1] ? 1'b0 : carry_d;
    end

    rsp_valid_d = (state_d == DONE);
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      timer_q     <= '0;
      res_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_cout_q  <= 1'b0;
      rsp_err_q   <= 1'b0;
      alu_req_q   <= 1'b0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= '0;
      alu_cin_q   <= 1'b0;
`ifdef NIBBLE_ALU_SEQUENCER_FLAGS_EN
      rsp_zero_q  <= 1'b0;
      rsp_ovf_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      timer_q     <= timer_d;
      res_q       <= res_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_cout_q  <= rsp_cout_d;
      rsp_err_q   <= rsp_err_d;
      alu_req_q   <= alu_req_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_op_q    <= alu_op_d;
      alu_cin_q   <= alu_cin_d;
`ifdef NIBBLE_ALU_SEQUENCER_FLAGS_EN
      rsp_zero_q  <= rsp_zero_d;
      rsp_ovf_q   <= rsp_ovf_d;
`endif
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_s     = res_q;
  assign rsp_cout  = rsp_cout_q;
  assign rsp_err   = rsp_err_q;
  assign alu_req   = alu_req_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_op    = alu_op_q;
  assign alu_cin   = alu_cin_q;
`ifdef NIBBLE_ALU_SEQUENCER_FLAGS_EN
  assign rsp_zero  = rsp_zero_q;
  assign rsp_ovf   = rsp_ovf_q;
`endif

endmodule

// File: tb/tb_nibble_alu_sequencer.sv
// -----------------------------------------------------------------------------
// tb_nibble_alu_sequencer
//
// Directed bench for nibble_alu_sequencer (WIDTH=16, TIMEOUT=15) with a
// behavioural nibble ALU that answers L=2 cycles after each alu_req.
// -----------------------------------------------------------------------------
module tb_nibble_alu_sequencer;

  localparam int L = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic [1:0]  req_op;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_s;
  logic        rsp_cout;
  logic        rsp_err;
`ifdef NIBBLE_ALU_SEQUENCER_FLAGS_EN
  logic        rsp_zero;
  logic        rsp_ovf;
`endif
  logic        alu_req;
  logic [3:0]  alu_a;
  logic [3:0]  alu_b;
  logic [1:0]  alu_op;
  logic        alu_cin;
  logic [3:0]  alu_s;
  logic        alu_cout;
  logic        alu_valid;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  nibble_alu_sequencer #(.WIDTH(16), .TIMEOUT(15)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_op    (req_op),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_s     (rsp_s),
    .rsp_cout  (rsp_cout),
    .rsp_err   (rsp_err),
`ifdef NIBBLE_ALU_SEQUENCER_FLAGS_EN
    .rsp_zero  (rsp_zero),
    .rsp_ovf   (rsp_ovf),
`endif
    .alu_req   (alu_req),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_op    (alu_op),
    .alu_cin   (alu_cin),
    .alu_s     (alu_s),
    .alu_cout  (alu_cout),
    .alu_valid (alu_valid)
  );

  // ---------------------------------------------------------------------------
  // Behavioural nibble ALU: {cout, s}
  // ---------------------------------------------------------------------------
  function automatic logic [4:0] nib_model(input logic [3:0] a, input logic [3:0] b,
                                           input logic [1:0] op, input logic cin);
    logic [4:0] r;
    case (op)
      2'b00:   r = {1'b0, a} + {1'b0, b} + {4'b0, cin};
      2'b01:   r = {1'b0, a} - {1'b0, b} - {4'b0, cin};
      2'b10:   r = {1'b0, a & b};
      default: r = {1'b0, a | b};
    endcase
    return r;
  endfunction

  logic        alu_en      = 1'b1;
  logic        force_valid = 1'b0;
  logic        model_valid = 1'b0;
  logic [3:0]  pend_s      = 4'h0;
  logic        pend_c      = 1'b0;
  int          cnt         = 0;
  int          pulse_n     = 0;
  logic [3:0]  log_a   [0:127];
  logic [3:0]  log_b   [0:127];
  logic [1:0]  log_op  [0:127];
  logic        log_cin [0:127];

  assign alu_valid = model_valid | force_valid;
  assign alu_s     = pend_s;
  assign alu_cout  = pend_c;

  // Mid-cycle model: a request seen in cycle k is answered during cycle k+L.
  always @(negedge clk) begin
    logic [4:0] r;
    model_valid = 1'b0;
    if (cnt > 0) begin
      cnt = cnt - 1;
      if (cnt == 0 && alu_en) model_valid = 1'b1;
    end
    if (alu_req) begin
      r      = nib_model(alu_a, alu_b, alu_op, alu_cin);
      pend_s = r[3:0];
      pend_c = r[4];
      cnt    = L;
      if (pulse_n < 128) begin
        log_a[pulse_n]   = alu_a;
        log_b[pulse_n]   = alu_b;
        log_op[pulse_n]  = alu_op;
        log_cin[pulse_n] = alu_cin;
      end
      pulse_n = pulse_n + 1;
    end
  end

  // ---------------------------------------------------------------------------
  // Checking and stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  int base = 0;

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op);
    int n;
    @(negedge clk);
    req_a     = a;
    req_b     = b;
    req_op    = op;
    req_valid = 1'b1;
    base      = pulse_n;
    n = 0;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("accept_timeout", {31'b0, req_ready}, 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  // Called 1 time unit after the accepting edge; returns just after the edge
  // on which rsp_valid rose.
  task automatic expect_rsp(input string tag, input logic [15:0] exp_s,
                            input logic exp_cout, input logic exp_err, input int exp_lat);
    int lat;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!rsp_valid && lat < 200);
    check({tag, "_lat"},  lat,                exp_lat);
    check({tag, "_s"},    {16'b0, rsp_s},     {16'b0, exp_s});
    check({tag, "_cout"}, {31'b0, rsp_cout},  {31'b0, exp_cout});
    check({tag, "_err"},  {31'b0, rsp_err},   {31'b0, exp_err});
    $display("rsp %s s=0x%04h cout=%0d err=%0d latency=%0d", tag, rsp_s, rsp_cout, rsp_err, lat);
  endtask

  task automatic chk_pulses(input string tag, input logic [15:0] a, input logic [15:0] b,
                            input logic [1:0] op, input logic [3:0] exp_cin);
    logic [15:0] got_a;
    logic [15:0] got_b;
    logic [3:0]  got_cin;
    logic [1:0]  got_op;
    got_a   = '0;
    got_b   = '0;
    got_cin = '0;
    got_op  = '0;
    check({tag, "_pulses"}, pulse_n - base, 4);
    for (int i = 0; i < 4; i++) begin
      if (base + i < 128) begin
        got_a[4*i +: 4] = log_a[base+i];
        got_b[4*i +: 4] = log_b[base+i];
        got_cin[i]      = log_cin[base+i];
        got_op          = got_op | log_op[base+i];
      end
    end
    check({tag, "_alu_a"},   {16'b0, got_a},   {16'b0, a});
    check({tag, "_alu_b"},   {16'b0, got_b},   {16'b0, b});
    check({tag, "_alu_op"},  {30'b0, got_op},  {30'b0, op});
    check({tag, "_alu_cin"}, {28'b0, got_cin}, {28'b0, exp_cin});
  endtask

  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic [1:0] op, input logic [15:0] exp_s,
                        input logic exp_cout, input logic [3:0] exp_cin);
    send(a, b, op);
    expect_rsp(tag, exp_s, exp_cout, 1'b0, 4 * (L + 1));
    chk_pulses(tag, a, b, op, exp_cin);
    @(posedge clk);
    #1;
    check({tag, "_rsp_clear"}, {31'b0, rsp_valid}, 32'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    int n;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_a     = '0;
    req_b     = '0;
    req_op    = '0;
    rsp_ready = 1'b1;

    #1;
    check("reset_outputs",
          {3'b0, rsp_valid, rsp_s, rsp_cout, rsp_err, alu_req, alu_a, alu_b, alu_op, alu_cin},
          32'd0);
    check("reset_req_ready", {31'b0, req_ready}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("idle_req_ready", {31'b0, req_ready}, 32'd1);

    // Arithmetic and logic vectors; expected cin is listed as bit i = nibble i.
    run_op("add",   16'h1234, 16'h0FCD, 2'b00, 16'h2201, 1'b0, 4'b1110);
    run_op("sub1",  16'h1000, 16'h0001, 2'b01, 16'h0FFF, 1'b0, 4'b1110);
    run_op("sub0",  16'h0000, 16'h0001, 2'b01, 16'hFFFF, 1'b1, 4'b1110);
    run_op("and",   16'hF0F0, 16'h3C3C, 2'b10, 16'h3030, 1'b0, 4'b0000);
    run_op("or",    16'h00F0, 16'h0F01, 2'b11, 16'h0FF1, 1'b0, 4'b0000);
    run_op("addcy", 16'hFFFF, 16'h0001, 2'b00, 16'h0000, 1'b1, 4'b1110);

    // Backpressure: response held while a new request waits.
    rsp_ready = 1'b0;
    send(16'hA5A5, 16'h0F0F, 2'b11);
    expect_rsp("bp_first", 16'hAFAF, 1'b0, 1'b0, 4 * (L + 1));
    req_a     = 16'h00FF;
    req_b     = 16'h0001;
    req_op    = 2'b00;
    req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("bp_hold_valid", {31'b0, rsp_valid}, 32'd1);
      check("bp_hold_s",     {16'b0, rsp_s},     32'h0000AFAF);
      check("bp_hold_ready", {31'b0, req_ready}, 32'd0);
    end
    base      = pulse_n;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_valid", {31'b0, rsp_valid}, 32'd0);
    check("bp_release_ready", {31'b0, req_ready}, 32'd1);
    @(posedge clk);
    #1;
    check("bp_accept_alu_req", {31'b0, alu_req},   32'd1);
    check("bp_accept_ready",   {31'b0, req_ready}, 32'd0);
    req_valid = 1'b0;
    expect_rsp("bp_second", 16'h0100, 1'b0, 1'b0, 4 * (L + 1));
    chk_pulses("bp_second", 16'h00FF, 16'h0001, 2'b00, 4'b0110);
    @(posedge clk);
    #1;
    check("bp_second_clear", {31'b0, rsp_valid}, 32'd0);

    // Timeout: ALU silent; 1 ISSUE edge + 16 WAIT edges.
    alu_en    = 1'b0;
    rsp_ready = 1'b0;
    send(16'h1111, 16'h2222, 2'b00);
    expect_rsp("tmo", 16'h0000, 1'b0, 1'b1, 17);
    check("tmo_pulses", pulse_n - base, 1);
    @(negedge clk);
    force_valid = 1'b1;
    @(negedge clk);
    force_valid = 1'b0;
    check("tmo_late_s",     {16'b0, rsp_s},     32'd0);
    check("tmo_late_err",   {31'b0, rsp_err},   32'd1);
    check("tmo_late_valid", {31'b0, rsp_valid}, 32'd1);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    check("tmo_clear", {30'b0, rsp_valid, rsp_err}, 32'd0);
    @(negedge clk);
    force_valid = 1'b1;
    @(negedge clk);
    force_valid = 1'b0;
    @(posedge clk);
    #1;
    check("idle_stale_ignored", {30'b0, rsp_valid, alu_req}, 32'd0);
    check("idle_stale_ready",   {31'b0, req_ready},          32'd1);
    alu_en = 1'b1;

    // Reset during the WAIT of nibble 2.
    send(16'h1234, 16'h0FCD, 2'b00);
    n = 0;
    while (pulse_n < base + 3 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("rst_reach_nibble2", pulse_n - base, 3);
    check("rst_pre_alu_a", {28'b0, alu_a}, 32'd2);
    #2;
    rst = 1'b1;
    #1;
    check("rst_async_outputs",
          {3'b0, rsp_valid, rsp_s, rsp_cout, rsp_err, alu_req, alu_a, alu_b, alu_op, alu_cin},
          32'd0);
    check("rst_async_ready", {31'b0, req_ready}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rst_release_idle", {30'b0, req_ready, rsp_valid}, 32'd2);
    run_op("post_rst", 16'h0001, 16'h0001, 2'b00, 16'h0002, 1'b0, 4'b0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
